// File: rtl/div_pkg.sv
// div_pkg -- shared definitions for the sequential restoring divider.
//   DIV_WIDTH     : default operand / quotient / remainder width
//   div_state_t   : one-hot FSM encoding (IDLE, LOAD, ITER, DONE)
//   DIV_ALL_ONES  : all-ones pattern; its low WIDTH bits are the
//                   quotient reported on divide-by-zero
package div_pkg;

    localparam int DIV_WIDTH = 8;

    typedef enum logic [3:0] {
        ST_IDLE = 4'b0001,
        ST_LOAD = 4'b0010,
        ST_ITER = 4'b0100,
        ST_DONE = 4'b1000
    } div_state_t;

    localparam logic [63:0] DIV_ALL_ONES = '1;

endpackage

// File: rtl/div_step.sv
// div_step -- one combinational shift-subtract step of a restoring divider.
//   rem_i     in  WIDTH  partial remainder (always < divisor_i)
//   bit_i     in  1      next dividend bit, MSB first
//   divisor_i in  WIDTH  divisor (non-zero)
//   rem_o     out WIDTH  updated partial remainder
//   q_bit_o   out 1      quotient bit produced by this step
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_bit_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    assign shifted = {rem_i, bit_i};
    assign diff    = shifted - {1'b0, divisor_i};

    // Because rem_i < divisor_i, shifted < 2*divisor: a non-negative
    // difference always fits in WIDTH bits, so the top bit of diff is
    // exactly the borrow (shifted < divisor).
    assign q_bit_o = ~diff[WIDTH];
    assign rem_o   = q_bit_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl -- sequencer for a multi-cycle unsigned restoring divider.
// One operand pair is accepted per start pulse (in IDLE or DONE); one
// shift-subtract step runs per clock; results are held from done until
// the next operation completes.
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   start           request, sampled only in IDLE or DONE
//   dividend/divisor operands, captured on the accepting edge
//   busy            high in LOAD/ITER
//   done            one-cycle pulse, results valid
//   quotient/remainder/div_by_zero  result registers
//   abort           only when DIV_ABORT_EN is defined: cancels a running
//                   operation (LOAD/ITER) back to IDLE, no done pulse,
//                   result registers untouched
module div_seq_ctrl
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
`ifdef DIV_ABORT_EN
    input  logic             abort,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] dvd_q;      // dividend shifting out MSB first, quotient shifting in
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] part_q;     // partial remainder
    logic [WIDTH-1:0] quot_q, rem_q;
    logic             dbz_q;

    logic             abort_w;
    logic             accept;
    logic [WIDTH-1:0] step_rem;
    logic             step_qbit;
    logic [WIDTH-1:0] dvd_shift;

`ifdef DIV_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    assign accept    = start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign dvd_shift = {dvd_q[WIDTH-2:0], step_qbit};

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (part_q),
        .bit_i     (dvd_q[WIDTH-1]),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .q_bit_o   (step_qbit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Abort is only examined in LOAD/ITER, so start always wins in IDLE/DONE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: state_d = start ? ST_LOAD : ST_IDLE;
            ST_LOAD: begin
                if (abort_w)            state_d = ST_IDLE;
                else if (dvs_q == '0)   state_d = ST_DONE;
                else                    state_d = ST_ITER;
            end
            ST_ITER: begin
                if (abort_w)               state_d = ST_IDLE;
                else if (cnt_q == LAST_CNT) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            dvd_q  <= '0;
            dvs_q  <= '0;
            part_q <= '0;
            quot_q <= '0;
            rem_q  <= '0;
            dbz_q  <= 1'b0;
        end else begin
            if (accept) begin
                dvd_q <= dividend;
                dvs_q <= divisor;
            end
            if (state_q == ST_LOAD && !abort_w) begin
                part_q <= '0;
                cnt_q  <= '0;
                if (dvs_q == '0) begin
                    quot_q <= DIV_ALL_ONES[WIDTH-1:0];
                    rem_q  <= dvd_q;
                    dbz_q  <= 1'b1;
                end
            end
            if (state_q == ST_ITER && !abort_w) begin
                part_q <= step_rem;
                dvd_q  <= dvd_shift;
                cnt_q  <= cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    quot_q <= dvd_shift;
                    rem_q  <= step_rem;
                    dbz_q  <= 1'b0;
                end
            end
        end
    end

    assign busy        = (state_q == ST_LOAD) || (state_q == ST_ITER);
    assign done        = (state_q == ST_DONE);
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// tb_div_seq_ctrl -- randomized self-checking bench for div_seq_ctrl
// (WIDTH=8). Expected results come from plain integer / and %.
// Define DIV_ABORT_EN to also exercise the abort port.
module tb_div_seq_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
`ifdef DIV_ABORT_EN
    logic         abort = 1'b0;
`endif
    logic         busy, done, div_by_zero;
    logic [W-1:0] quotient, remainder;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    logic [W-1:0] last_q, last_r;
    logic         last_z;

    always #5 clk = ~clk;

    div_seq_ctrl #(.WIDTH(W), .CNT_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
`ifdef DIV_ABORT_EN
        .abort       (abort),
`endif
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Present an operand pair with start for one edge; scramble operands afterwards.
    task automatic accept_op(input int a, input int b);
        start    = 1'b1;
        dividend = W'(a);
        divisor  = W'(b);
        tick();
        cyc      = 0;
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
        check_val("busy_after_accept", {31'd0, busy}, 32'd1);
        check_val("done_low_after_accept", {31'd0, done}, 32'd0);
    endtask

    task automatic wait_done(input int a, input int b);
        logic [W-1:0] eq, er;
        logic         ez;
        int           exp_lat;
        ez      = (b == 0);
        eq      = ez ? W'(255) : W'(a / b);
        er      = ez ? W'(a) : W'(a % b);
        exp_lat = ez ? 1 : W + 1;
        while (!done && cyc < 40) tick();
        check_val("latency", cyc, exp_lat);
        check_val("busy_at_done", {31'd0, busy}, 32'd0);
        check_val("quotient", {24'd0, quotient}, {24'd0, eq});
        check_val("remainder", {24'd0, remainder}, {24'd0, er});
        check_val("div_by_zero", {31'd0, div_by_zero}, {31'd0, ez});
        last_q = eq;
        last_r = er;
        last_z = ez;
        $display("op %0d/%0d -> q=%0d r=%0d dbz=%0d lat=%0d", a, b, quotient, remainder, div_by_zero, cyc);
    endtask

    // One idle edge after done: pulse must end and results must hold.
    task automatic check_idle_hold();
        tick();
        check_val("done_one_cycle", {31'd0, done}, 32'd0);
        check_val("busy_idle", {31'd0, busy}, 32'd0);
        check_val("q_held", {24'd0, quotient}, {24'd0, last_q});
        check_val("r_held", {24'd0, remainder}, {24'd0, last_r});
        check_val("z_held", {31'd0, div_by_zero}, {31'd0, last_z});
    endtask

    task automatic run_op(input int a, input int b);
        accept_op(a, b);
        wait_done(a, b);
        check_idle_hold();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check_val({tag, "_done"}, {31'd0, done}, 32'd0);
        check_val({tag, "_q"}, {24'd0, quotient}, 32'd0);
        check_val({tag, "_r"}, {24'd0, remainder}, 32'd0);
        check_val({tag, "_z"}, {31'd0, div_by_zero}, 32'd0);
    endtask

    initial begin
        #3;
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        check_reset_outputs("post_reset_idle");

        // Directed cases
        run_op(100, 7);
        run_op(255, 1);
        run_op(3, 200);
        run_op(255, 255);
        run_op(13, 0);

        // start during ITER is ignored; start in DONE is accepted back-to-back
        accept_op(100, 7);
        repeat (3) tick();
        start = 1'b1; dividend = 8'd50; divisor = 8'd5;
        tick();
        start = 1'b0;
        wait_done(100, 7);
        accept_op(50, 5);
        wait_done(50, 5);
        check_idle_hold();

        // Asynchronous reset in the middle of ITER
        accept_op(100, 7);
        repeat (5) tick();
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        run_op(9, 2);

`ifdef DIV_ABORT_EN
        // Abort during ITER: back to IDLE, no done, results unchanged
        accept_op(100, 7);
        repeat (4) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_val("abort_busy", {31'd0, busy}, 32'd0);
        for (int k = 0; k < 12; k++) begin
            check_val("abort_no_done", {31'd0, done}, 32'd0);
            tick();
        end
        check_val("abort_q_kept", {24'd0, quotient}, {24'd0, last_q});
        check_val("abort_r_kept", {24'd0, remainder}, {24'd0, last_r});
        run_op(20, 6);
        // abort together with start in IDLE: start wins
        abort = 1'b1;
        accept_op(77, 8);
        abort = 1'b0;
        wait_done(77, 8);
        check_idle_hold();
`endif

        // Randomized operations, mixing idle gaps and back-to-back starts
        for (int i = 0; i < 40; i++) begin
            int a, b;
            a = int'($urandom_range(0, 255));
            b = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255));
            accept_op(a, b);
            wait_done(a, b);
            if ($urandom_range(0, 1) == 1) begin
                check_idle_hold();
                repeat ($urandom_range(0, 2)) tick();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
